// File: rtl/sobel_3x3_filter_if.sv
// Pixel-stream bundle for sobel_3x3_filter: the input pixel with its controls,
// and the gradient result returned by the filter.
interface sobel_3x3_filter_if #(
    parameter int CH_BITS = 4,
    parameter int NUM_CH  = 3
);
    logic                      inValid;
    logic                      inSof;
    logic [NUM_CH*CH_BITS-1:0] pixelIn;
    logic                      mode;
    logic [CH_BITS-1:0]        thresh;
    logic                      outValid;
    logic [CH_BITS-1:0]        outMag;
    logic                      outEdge;

    modport master (
        output inValid, inSof, pixelIn, mode, thresh,
        input  outValid, outMag, outEdge
    );

    modport slave (
        input  inValid, inSof, pixelIn, mode, thresh,
        output outValid, outMag, outEdge
    );
endinterface

// File: rtl/sobel_3x3_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers feed a 3x3 window; the
// per-channel |Gx|+|Gy| is combined by max or sum, shifted, saturated and thresholded.
module sobel_3x3_filter #(
    parameter int IMG_WIDTH = 640,
    parameter int CH_BITS   = 4,
    parameter int NUM_CH    = 3,
    parameter int MAG_SHIFT = 2
) (
    input logic              clk25,
    input logic              reset,
    sobel_3x3_filter_if.slave io
);
    localparam int PIX_W = NUM_CH * CH_BITS;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = 11;
    localparam int G_W   = CH_BITS + 3;
    localparam int MAG_W = CH_BITS + 4;
    localparam int SUM_W = MAG_W + $clog2(NUM_CH);
    localparam logic [CH_BITS-1:0] SAT = '1;

    logic [COL_W-1:0] col, col_eff;
    logic [ROW_W-1:0] row, row_eff;

    // inSof overrides the counters for the pixel it qualifies, including a wrap.
    assign col_eff = io.inSof ? '0 : col;
    assign row_eff = io.inSof ? '0 : row;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (io.inValid) begin
            if (col_eff == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row_eff == '1) ? row_eff : row_eff + ROW_W'(1);
            end else begin
                col <= col_eff + COL_W'(1);
                row <= row_eff;
            end
        end
    end

    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] up1, up2;

    assign up1 = lb1[col_eff];
    assign up2 = lb2[col_eff];

    always_ff @(posedge clk25) begin
        if (io.inValid) begin
            lb1[col_eff] <= io.pixelIn;
            lb2[col_eff] <= up1;
        end
    end

    // win[row][col]: row 0 = r-2 (top), col 2 = newest column c.
    logic [PIX_W-1:0]   win [3][3];
    logic               v1, mask1, mode1;
    logic [CH_BITS-1:0] th1;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++)
                for (int unsigned j = 0; j < 3; j++)
                    win[i][j] <= '0;
            v1    <= 1'b0;
            mask1 <= 1'b0;
            mode1 <= 1'b0;
            th1   <= '0;
        end else begin
            v1 <= io.inValid;
            if (io.inValid) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= up2;
                win[1][2] <= up1;
                win[2][2] <= io.pixelIn;
                mask1     <= (row_eff <= ROW_W'(1)) || (col_eff <= COL_W'(1));
                mode1     <= io.mode;
                th1       <= io.thresh;
            end
        end
    end

    logic signed [G_W-1:0] p [3][3];
    logic signed [G_W-1:0] gx, gy;
    logic [G_W-1:0]        ax, ay;
    logic [MAG_W-1:0]      mag;
    logic [SUM_W-1:0]      comb_next;

    always_comb begin
        p         = '{default: '0};
        gx        = '0;
        gy        = '0;
        ax        = '0;
        ay        = '0;
        mag       = '0;
        comb_next = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned i = 0; i < 3; i++)
                for (int unsigned j = 0; j < 3; j++)
                    p[i][j] = signed'(G_W'(win[i][j][ch*CH_BITS +: CH_BITS]));
            gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
            gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
            ax = gx[G_W-1] ? $unsigned(-gx) : $unsigned(gx);
            ay = gy[G_W-1] ? $unsigned(-gy) : $unsigned(gy);
            mag = MAG_W'(ax) + MAG_W'(ay);
            if (mode1)
                comb_next = comb_next + SUM_W'(mag);
            else if (SUM_W'(mag) > comb_next)
                comb_next = SUM_W'(mag);
        end
    end

    logic               v2, mask2;
    logic [CH_BITS-1:0] th2;
    logic [SUM_W-1:0]   comb2;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            v2    <= 1'b0;
            mask2 <= 1'b0;
            th2   <= '0;
            comb2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                mask2 <= mask1;
                th2   <= th1;
                comb2 <= comb_next;
            end
        end
    end

    logic [SUM_W-1:0]   shifted;
    logic [CH_BITS-1:0] sat_mag;

    assign shifted = comb2 >> MAG_SHIFT;
    assign sat_mag = (shifted > SUM_W'(SAT)) ? SAT : shifted[CH_BITS-1:0];

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            io.outValid <= 1'b0;
            io.outMag   <= '0;
            io.outEdge  <= 1'b0;
        end else begin
            io.outValid <= v2;
            if (v2) begin
                io.outMag  <= mask2 ? '0 : sat_mag;
                io.outEdge <= !mask2 && (sat_mag >= th2);
            end
        end
    end
endmodule

// File: doc/sobel_3x3_filter.md
SOBEL_3X3_FILTER -- requirements
Module: sobel_3x3_filter

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (2..1024).
REQ-002 Parameter CH_BITS, default 4, bits per colour channel.
REQ-003 Parameter NUM_CH, default 3, channel count, MSB-first packing (R,G,B).
REQ-004 Parameter MAG_SHIFT, default 2, right shift applied to raw magnitude before saturation.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk25  input  1  pixel clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 inValid  input  1  pixel on pixelIn accepted this cycle.
REQ-009 inSof  input  1  qualified by inValid; accepted pixel is row 0, col 0.
REQ-010 pixelIn  input  NUM_CH*CH_BITS  packed input pixel.
REQ-011 mode  input  1  0 = max over channels, 1 = sum over channels.
REQ-012 thresh  input  CH_BITS  edge threshold.
REQ-013 outValid  output  1  outMag/outEdge valid this cycle.
REQ-014 outMag  output  CH_BITS  saturated gradient magnitude.
REQ-015 outEdge  output  1  outMag >= thresh.

Function
REQ-016 Column counter advances on each accepted pixel and wraps IMG_WIDTH-1 -> 0, incrementing the row counter; the row counter saturates at its maximum.
REQ-017 inSof with inValid forces the accepted pixel to (0,0); its precedence over wrap is absolute.
REQ-018 Two line buffers (depth IMG_WIDTH, width NUM_CH*CH_BITS) hold rows r-1 and r-2; a 3x3 window register shifts only on accepted pixels; gaps in inValid freeze the window, counters and buffers.
REQ-019 For accepted pixel (r,c), the window center is (r-1,c-1).
REQ-020 Per channel: Gx = (right col) - (left col) with weights 1,2,1; Gy = (bottom row) - (top row) with weights 1,2,1; signed, CH_BITS+3 bits, no overflow.
REQ-021 Per channel raw magnitude = |Gx| + |Gy|, CH_BITS+4 bits, unsigned.
REQ-022 mode=0: combined = max over channels; mode=1: combined = sum over channels, width sufficient for NUM_CH terms.
REQ-023 outMag = min(combined >> MAG_SHIFT, 2^CH_BITS-1).
REQ-024 outEdge = (outMag >= thresh); thresh=0 yields outEdge=1 on every unmasked output.
REQ-025 Border mask: when accepted r<=1 or c<=1, outMag=0 and outEdge=0 regardless of thresh; outValid still asserted.
REQ-026 Latency: exactly 3 clk25 cycles from accepting cycle to outValid; one output per accepted pixel, in order, no bubbles added.
REQ-027 mode and thresh sampled in the same pipeline stage as the pixel they apply to; mid-frame changes affect only later pixels.
REQ-028 Final image row and final column are never output as center; no flush.

Reset
REQ-029 Reset clears counters to (0,0), window registers to 0, valid pipeline to 0; outValid=0, outMag=0, outEdge=0 while reset high and until first valid output.
REQ-030 Line buffer contents are not reset; the border mask prevents stale data reaching outputs.
REQ-031 Reset mid-frame: in-flight outputs discarded; the next accepted pixel is (0,0) with or without inSof.

Verification
REQ-032 IMG_WIDTH=8, uniform frame value 0x777, mode=0, thresh=1 -> every outValid has outMag=0, outEdge=0.
REQ-033 IMG_WIDTH=8, R=0 cols 0-3, R=15 cols 4-7, G=B=0, mode=0, thresh=8 -> for rows >=1 and center cols 3 and 4 outMag=15, outEdge=1; all other centers outMag=0.
REQ-034 Same step in all three channels, mode=1 -> sum=180, >>2=45, outMag saturates to 15; mode=0 -> 15.
REQ-035 Continuous inValid vs. inValid every third cycle with identical pixels -> identical output sequence; each outValid exactly 3 cycles after its accepting cycle.
REQ-036 Assert reset for one cycle mid-row 3 -> outValid low from reset edge, next accepted pixel treated as (0,0), first two rows of outputs masked to 0.
REQ-037 inSof asserted mid-line at col 5 -> counters restart at (0,0); following outputs masked for r<=1, c<=1.
